// File: rtl/keccak_sponge_sequencer.sv
// keccak_sponge_sequencer
//
// Session scheduler that sits between a host bus and the masked Keccak core's
// control interface. It only sequences control signals. State data moves
// directly between the host and the core and never passes through this block.
//
// A session runs as follows:
//   1. It absorbs pre-padded rate blocks. Each accepted block issues one
//      absorb start.
//   2. It waits for each permutation to finish. The first cycle of that wait
//      is a blanking cycle.
//   3. It presents squeezed blocks to the host. Every block after the first
//      needs a squeeze start.
//   4. It pulses DonexSO when the last requested block has been taken.
//
// Optional feature: define KECCAK_SEQ_TIMEOUT_EN to add a permutation
// watchdog. If CoreReadyxSI does not return within TIMEOUT_CYCLES cycles of
// PERM_WAIT, the block enters a sticky ERROR state. Only reset leaves ERROR.
//
// Ports
//   ClkxCI, RstxRBI          clock, asynchronous active-low reset
//   StartxSI                 begin a session (sampled in IDLE only)
//   SqueezeBlocksxDI         output blocks wanted (0 means 1), sampled with start
//   AbortxSI                 abandon the session
//   InValidxSI/InLastxSI     host rate block valid / final padded block
//   InReadyxSO               block accepted when InValidxSI is also high
//   OutValidxSO/OutReadyxSI  squeezed block available / consumed by host
//   CoreReadyxSI             core idle
//   RandomnessAvailablexSI   fresh masking randomness present
//   CoreStartAbsorbxSO       absorb start pulse to core
//   CoreStartSqueezexSO      squeeze start pulse to core
//   BusyxSO                  session active
//   DonexSO                  one-cycle pulse on normal completion
//   BlockCountxDO            blocks absorbed this session (saturating)
//   ErrorxSO                 watchdog fired (sticky)

module keccak_sponge_sequencer #(
  parameter int RATE              = 128,
  parameter int W                 = 16,
  parameter int SQUEEZE_CNT_WIDTH = 8,
  parameter int BLOCK_CNT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         ClkxCI,
  input  logic                         RstxRBI,
  input  logic                         StartxSI,
  input  logic [SQUEEZE_CNT_WIDTH-1:0] SqueezeBlocksxDI,
  input  logic                         AbortxSI,
  input  logic                         InValidxSI,
  input  logic                         InLastxSI,
  output logic                         InReadyxSO,
  output logic                         OutValidxSO,
  input  logic                         OutReadyxSI,
  input  logic                         CoreReadyxSI,
  input  logic                         RandomnessAvailablexSI,
  output logic                         CoreStartAbsorbxSO,
  output logic                         CoreStartSqueezexSO,
  output logic                         BusyxSO,
  output logic                         DonexSO,
  output logic [BLOCK_CNT_WIDTH-1:0]   BlockCountxDO,
  output logic                         ErrorxSO
);

  // Reject parameter sets that cannot describe a real sponge configuration.
  if (RATE <= 0 || W <= 0 || (RATE % W) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("keccak_sponge_sequencer: illegal RATE/W/TIMEOUT_CYCLES combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PERM_WAIT,
    S_OUTPUT,
    S_SQUEEZE
`ifdef KECCAK_SEQ_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  state_t                       state_q, state_d;
  logic [SQUEEZE_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [BLOCK_CNT_WIDTH-1:0]   block_count_q, block_count_d;
  logic                         last_q, last_d;
  logic                         abort_q, abort_d;
  logic                         blank_q;
  logic                         done_q, done_d;
  logic                         core_go;

`ifdef KECCAK_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_expired;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // The core may start only when it is idle and randomness is available.
  assign core_go = CoreReadyxSI & RandomnessAvailablexSI;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_d             = state_q;
    remaining_d         = remaining_q;
    block_count_d       = block_count_q;
    last_d              = last_q;
    abort_d             = abort_q;
    done_d              = 1'b0;
    InReadyxSO          = 1'b0;
    CoreStartAbsorbxSO  = 1'b0;
    CoreStartSqueezexSO = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (StartxSI) begin
          state_d       = S_ABSORB;
          remaining_d   = (SqueezeBlocksxDI == '0) ? SQUEEZE_CNT_WIDTH'(1) : SqueezeBlocksxDI;
          block_count_d = '0;
          last_d        = 1'b0;
          abort_d       = 1'b0;
        end
      end

      S_ABSORB: begin
        // Abort wins over a simultaneous handshake. InReadyxSO is also
        // gated, so the host never sees its block as accepted.
        if (AbortxSI) begin
          state_d = S_IDLE;
        end else begin
          InReadyxSO = core_go;
          if (core_go && InValidxSI) begin
            CoreStartAbsorbxSO = 1'b1;
            if (block_count_q != '1) block_count_d = block_count_q + 1'b1;
            last_d  = InLastxSI;
            state_d = S_PERM_WAIT;
          end
        end
      end

      S_PERM_WAIT: begin
        // The permutation cannot be interrupted. An abort is only remembered
        // here and takes effect once the core reports ready.
        if (AbortxSI) abort_d = 1'b1;
        if (!blank_q && CoreReadyxSI) begin
          abort_d = 1'b0;
          if (abort_q || AbortxSI) state_d = S_IDLE;
          else if (last_q)         state_d = S_OUTPUT;
          else                     state_d = S_ABSORB;
        end
`ifdef KECCAK_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = S_ERROR;
        end
`endif
      end

      S_OUTPUT: begin
        if (AbortxSI) begin
          state_d = S_IDLE;
        end else if (OutReadyxSI) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == SQUEEZE_CNT_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SQUEEZE;
          end
        end
      end

      S_SQUEEZE: begin
        if (AbortxSI) begin
          state_d = S_IDLE;
        end else if (core_go) begin
          CoreStartSqueezexSO = 1'b1;
          state_d             = S_PERM_WAIT;
        end
      end

`ifdef KECCAK_SEQ_TIMEOUT_EN
      S_ERROR: state_d = S_ERROR;
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // values from before the clock edge.
  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      block_count_q <= '0;
      last_q        <= 1'b0;
      abort_q       <= 1'b0;
      blank_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      block_count_q <= block_count_d;
      last_q        <= last_d;
      abort_q       <= abort_d;
      // High only during the first PERM_WAIT cycle after a start. CoreReadyxSI
      // may not have dropped yet in that cycle.
      blank_q       <= (state_d == S_PERM_WAIT) && (state_q != S_PERM_WAIT);
      done_q        <= done_d;
    end
  end

`ifdef KECCAK_SEQ_TIMEOUT_EN
  // Holds at zero outside PERM_WAIT, so every PERM_WAIT entry starts from zero.
  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI)                  wd_q <= '0;
    else if (state_q != S_PERM_WAIT) wd_q <= '0;
    else                           wd_q <= wd_q + 1'b1;
  end
  assign ErrorxSO = (state_q == S_ERROR);
`else
  assign ErrorxSO = 1'b0;
`endif

  assign OutValidxSO   = (state_q == S_OUTPUT);
  assign BusyxSO       = (state_q != S_IDLE);
  assign DonexSO       = done_q;
  assign BlockCountxDO = block_count_q;

endmodule

// File: tb/tb_keccak_sponge_sequencer.sv
// Directed testbench for keccak_sponge_sequencer.
//
// Inputs change 1 ns after the rising edge, and outputs are compared a few ns
// later, well away from the edge. A small core model can drive CoreReady low
// for 20 cycles after every start pulse. Background counters tally start,
// done and output-handshake pulses at each falling edge.
module tb_keccak_sponge_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  sq_blocks;
  logic        abort;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        core_ready;
  logic        rand_av;
  logic        st_abs;
  logic        st_sq;
  logic        busy;
  logic        done;
  logic [15:0] block_count;
  logic        error;

  logic core_auto;
  logic core_manual;
  logic auto_rdy;

  int total;
  int bad;
  int n_abs, n_sq, n_done, n_out, n_both;
  int a0, s0, d0, o0;

  keccak_sponge_sequencer #(
    .RATE(128), .W(16), .SQUEEZE_CNT_WIDTH(8), .BLOCK_CNT_WIDTH(16), .TIMEOUT_CYCLES(64)
  ) dut (
    .ClkxCI                 (clk),
    .RstxRBI                (rst_n),
    .StartxSI               (start),
    .SqueezeBlocksxDI       (sq_blocks),
    .AbortxSI               (abort),
    .InValidxSI             (in_valid),
    .InLastxSI              (in_last),
    .InReadyxSO             (in_ready),
    .OutValidxSO            (out_valid),
    .OutReadyxSI            (out_ready),
    .CoreReadyxSI           (core_ready),
    .RandomnessAvailablexSI (rand_av),
    .CoreStartAbsorbxSO     (st_abs),
    .CoreStartSqueezexSO    (st_sq),
    .BusyxSO                (busy),
    .DonexSO                (done),
    .BlockCountxDO          (block_count),
    .ErrorxSO               (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign core_ready = core_auto ? auto_rdy : core_manual;

  // Core model: CoreReady drops after each start pulse and returns 20 cycles
  // later.
  initial begin
    int  cnt;
    logic seen;
    cnt      = 0;
    auto_rdy = 1'b1;
    forever begin
      @(negedge clk);
      seen = st_abs | st_sq;
      @(posedge clk);
      #1;
      if (!core_auto) begin
        cnt      = 0;
        auto_rdy = 1'b1;
      end else if (seen) begin
        cnt      = 20;
        auto_rdy = 1'b0;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) auto_rdy = 1'b1;
      end
    end
  end

  initial begin
    n_abs = 0; n_sq = 0; n_done = 0; n_out = 0; n_both = 0;
    forever begin
      @(negedge clk);
      if (st_abs) n_abs++;
      if (st_sq) n_sq++;
      if (done) n_done++;
      if (out_valid && out_ready) n_out++;
      if (st_abs && st_sq) n_both++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input string tag);
    #2;
    for (int k = 0; k < 200 && !in_ready; k++) begin
      next_cycle();
      #2;
    end
    check(tag, in_ready, 1);
  endtask

  task automatic wait_out_valid(input string tag);
    #2;
    for (int k = 0; k < 200 && !out_valid; k++) begin
      next_cycle();
      #2;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with every input high.
    rst_n = 1'b0; start = 1'b1; sq_blocks = 8'hFF; abort = 1'b1; in_valid = 1'b1;
    in_last = 1'b1; out_ready = 1'b1; rand_av = 1'b1; core_auto = 1'b0; core_manual = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_start_abs", st_abs, 0);
    check("rst_start_sq", st_sq, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_block_count", block_count, 0);
    check("rst_error", error, 0);

    // Release reset and start with SqueezeBlocks=0. ABSORB follows one cycle later.
    next_cycle();
    rst_n = 1'b1; start = 1'b1; sq_blocks = 8'd0; abort = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;
    #2;
    check("start_cycle_busy", busy, 0);
    next_cycle();
    start = 1'b0;
    #2;
    check("absorb_busy", busy, 1);
    check("absorb_in_ready", in_ready, 1);
    check("absorb_block_count", block_count, 0);

    // Abort in ABSORB together with a valid block.
    in_valid = 1'b1; abort = 1'b1;
    #1;
    check("abort_abs_in_ready", in_ready, 0);
    check("abort_abs_no_start", st_abs, 0);
    next_cycle();
    abort = 1'b0; in_valid = 1'b0;
    #2;
    check("abort_abs_idle", busy, 0);

    // Three blocks, two output blocks, core busy for 20 cycles per start.
    a0 = n_abs; s0 = n_sq; d0 = n_done; o0 = n_out;
    core_auto = 1'b1;
    start = 1'b1; sq_blocks = 8'd2;
    next_cycle();
    start = 1'b0; sq_blocks = 8'd0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_last  = (b == 2);
      wait_in_ready("blk_accept");
      next_cycle();
      in_valid = 1'b0; in_last = 1'b0;
      #2;
      check("blk_count", block_count, b + 1);
      check("blk_perm_busy", busy, 1);
    end
    wait_out_valid("out1_valid");
    next_cycle();
    #2;
    check("out1_hold", out_valid, 1);
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    #2;
    check("out1_no_done", done, 0);
    check("out1_busy", busy, 1);
    wait_out_valid("out2_valid");
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    #2;
    check("out2_done", done, 1);
    check("out2_busy", busy, 0);
    check("out2_block_count", block_count, 3);
    next_cycle();
    #2;
    check("done_single", done, 0);
    check("n_absorb_starts", n_abs - a0, 3);
    check("n_squeeze_starts", n_sq - s0, 1);
    check("n_done_pulses", n_done - d0, 1);
    check("n_out_handshakes", n_out - o0, 2);
    check("no_dual_start", n_both, 0);

    // Randomness unavailable for 10 cycles in ABSORB.
    core_auto = 1'b0; core_manual = 1'b1; rand_av = 1'b0;
    start = 1'b1; sq_blocks = 8'd1;
    next_cycle();
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b1;
    a0 = n_abs;
    for (int i = 0; i < 10; i++) begin
      #2;
      check("no_rand_in_ready", in_ready, 0);
      next_cycle();
    end
    rand_av = 1'b1;
    #2;
    check("rand_in_ready", in_ready, 1);
    check("rand_start_abs", st_abs, 1);
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    #2;
    check("rand_one_start", n_abs - a0, 1);

    // Abort latched in PERM_WAIT. Core ready returns 15 cycles later.
    core_manual = 1'b0; abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    repeat (14) next_cycle();
    core_manual = 1'b1;
    #2;
    check("perm_abort_still_busy", busy, 1);
    a0 = n_abs; s0 = n_sq; d0 = n_done;
    next_cycle();
    #2;
    check("perm_abort_idle", busy, 0);
    check("perm_abort_no_out", out_valid, 0);
    repeat (3) next_cycle();
    #2;
    check("perm_abort_no_done", n_done - d0, 0);
    check("perm_abort_no_abs", n_abs - a0, 0);
    check("perm_abort_no_sq", n_sq - s0, 0);

    // Blanking cycle, then abort in OUTPUT together with OutReady.
    start = 1'b1; sq_blocks = 8'd1;
    next_cycle();
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b1;
    wait_in_ready("t5_accept");
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    #2;
    check("blank_no_out", out_valid, 0);
    next_cycle();
    #2;
    check("sample_no_out", out_valid, 0);
    next_cycle();
    #2;
    check("ready_to_out", out_valid, 1);
    d0 = n_done;
    abort = 1'b1; out_ready = 1'b1;
    next_cycle();
    abort = 1'b0; out_ready = 1'b0;
    #2;
    check("out_abort_idle", busy, 0);
    check("out_abort_no_done", done, 0);
    next_cycle();
    #2;
    check("out_abort_no_done_cnt", n_done - d0, 0);

    // SqueezeBlocks=0 means one block. StartxSI outside IDLE is ignored.
    start = 1'b1; sq_blocks = 8'd0;
    next_cycle();
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b1;
    wait_in_ready("t6_accept");
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0;
    start = 1'b1; sq_blocks = 8'd3;
    next_cycle();
    start = 1'b0; sq_blocks = 8'd0;
    wait_out_valid("t6_out_valid");
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    #2;
    check("zero_blocks_done", done, 1);
    check("zero_blocks_idle", busy, 0);
    check("zero_blocks_count", block_count, 1);

    // Core ready held low after an absorb start.
    start = 1'b1; sq_blocks = 8'd1;
    next_cycle();
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b1;
    wait_in_ready("t7_accept");
    next_cycle();
    in_valid = 1'b0; in_last = 1'b0; core_manual = 1'b0;
    repeat (63) next_cycle();
    #2;
    check("wd_pre_error", error, 0);
    check("wd_pre_busy", busy, 1);
    next_cycle();
    #2;
`ifdef KECCAK_SEQ_TIMEOUT_EN
    check("wd_error", error, 1);
    check("wd_error_busy", busy, 1);
    start = 1'b1; core_manual = 1'b1;
    repeat (5) next_cycle();
    #2;
    check("wd_error_sticky", error, 1);
    check("wd_error_sticky_busy", busy, 1);
    check("wd_error_no_out", out_valid, 0);
    start = 1'b0;
`else
    check("no_wd_error", error, 0);
    check("no_wd_busy", busy, 1);
    check("no_wd_no_out", out_valid, 0);
    repeat (100) next_cycle();
    #2;
    check("no_wd_still_waiting", busy, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
